rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Reset sequencer and lock supervisor for the clock-generator MMCM.
- Watches the MMCM `locked` flag, requires it to stay stable before releasing anything, then releases domain resets in the fixed order mem -> periph -> core.
- Re-enters reset on lock loss, on a software reset request, or on a debounced board reset button.
- Sits beside the clock generator in the top level, clocked by the 100 MHz output.

Parameters:
- SYNC_STAGES, 2: flop stages on the asynchronous inputs `locked` and `btn_rst`; must be ≥2.
- CNT_W, 20: width of the shared internal cycle counters.
- LOCK_STABLE_CYC, 1024: consecutive synchronized-locked cycles required before the first release; range 1..2^CNT_W-1.
- STEP_CYC, 16: cycles between successive reset releases; range 1..2^CNT_W-1.
- HOLD_CYC, 64: minimum cycles all resets are held after a sw or button request; range 1..2^CNT_W-1.
- DEBOUNCE_CYC, 100000: cycles `btn_rst` must hold a new level to be accepted (1 ms at 100 MHz); range 1..2^CNT_W-1.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  MMCM lock flag; asynchronous to clk.
- sw_rst_req  in  1  software reset request; single-cycle pulse, synchronous to clk.
- btn_rst  in  1  raw board reset button, active-high; asynchronous.
- rst_mem  out  1  memory-domain reset, active-high, registered.
- rst_periph  out  1  peripheral-domain reset, active-high, registered.
- rst_core  out  1  CPU-core reset, active-high, registered.
- ready  out  1  high only when all domains are out of reset.
- state  out  3  current FSM state encoding, for debug.
- lock_loss_cnt  out  8  lock-loss event counter (optional feature).

Behaviour:
- Reset: clk and rst are the single clock and reset; reset is synchronous and active-high. On rst=1 at an edge:
  - rst_mem/rst_periph/rst_core = 1, ready = 0.
  - state = S_WAIT_LOCK (0).
  - All counters, sync flops and the debounced button level = 0; lock_loss_cnt = 0.
- Reset applies mid-sequence with the same result.
- Sync: `locked` and `btn_rst` each pass through SYNC_STAGES flops; their outputs are locked_s and btn_s.
- FSM states and encodings: S_WAIT_LOCK=0, S_SEQ_MEM=1, S_SEQ_PERIPH=2, S_RUN=3, S_HOLD=4.
- S_WAIT_LOCK: all resets = 1.
  - Stable counter increments on each edge with locked_s=1 and clears when locked_s=0.
  - On the edge where the count reaches LOCK_STABLE_CYC: go to S_SEQ_MEM, rst_mem <= 0, step counter cleared.
  - rst_mem therefore falls exactly SYNC_STAGES+LOCK_STABLE_CYC edges after the first edge that samples locked=1.
- S_SEQ_MEM: after STEP_CYC edges, rst_periph <= 0 and go to S_SEQ_PERIPH.
- S_SEQ_PERIPH: after STEP_CYC edges, rst_core <= 0, ready <= 1, go to S_RUN.
- S_RUN: hold until an event below occurs.
- Lock loss: locked_s=0 in S_SEQ_MEM, S_SEQ_PERIPH or S_RUN.
  - Next edge: all resets = 1, ready = 0, go to S_WAIT_LOCK, stable counter cleared.
  - Resulting latency from `locked` falling is SYNC_STAGES+1 edges.
  - Lock loss is ignored in S_HOLD; S_WAIT_LOCK handles it afterwards.
- Reset request: sw_rst_req=1, or the rising edge of the debounced button level.
  - Honoured in S_SEQ_MEM, S_SEQ_PERIPH and S_RUN.
  - Next edge: all resets = 1, ready = 0, go to S_HOLD.
  - Ignored in S_WAIT_LOCK and S_HOLD.
- S_HOLD: after exactly HOLD_CYC edges, go to S_WAIT_LOCK with the stable counter cleared, so the full stability wait repeats.
- Priority when events coincide: rst > lock loss > reset request.
- Debounce:
  - Debounced level toggles only after btn_s differs from it for DEBOUNCE_CYC consecutive edges; any agreeing cycle clears the count.
  - A request is generated for one cycle on the 0->1 change only.
  - A held button produces exactly one request.
- Release order is strictly mem, periph, core. No output glitches: all outputs come straight from flops.
- Counters saturate and never wrap.

Optional Feature:
- Macro: RST_SEQ_LOCK_LOSS_CNT_EN.
- Defined:
  - lock_loss_cnt increments by 1 on each lock-loss transition (S_SEQ_MEM/S_SEQ_PERIPH/S_RUN -> S_WAIT_LOCK).
  - It saturates at 255 and clears only on rst.
- Undefined: lock_loss_cnt is tied to 8'd0 and no counter logic is built.

Test Plan:
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYC=8, STEP_CYC=4, HOLD_CYC=6, DEBOUNCE_CYC=5.
1. Power-up: rst for 3 cycles, then locked=1 from edge 1 -> rst_mem falls at edge 10, rst_periph at edge 14, rst_core and ready=1 at edge 18, state=3.
2. Unstable lock: locked=1 for 5 cycles, 0 for 1, then 1 -> no release until 10 edges after the re-rise; the counter restarts.
3. Lock loss in S_RUN: drop locked at edge N -> all resets=1 and ready=0 at edge N+3, state=0. Restore lock -> full sequence repeats; lock_loss_cnt=1 with the macro, 0 without it.
4. sw_rst_req pulse in S_RUN at edge N -> resets asserted at N+1, state=4 for 6 edges, state=0 at N+7, release 8 edges after that. A second pulse during S_HOLD has no effect.
5. Button: 3-cycle bounce then held high for 20 cycles -> exactly one request, landing on the edge 5 cycles after btn_s settles high; the 3-cycle bounce alone produces no request.
6. Simultaneous lock loss and sw_rst_req in S_SEQ_PERIPH -> state=0 (lock loss wins), not 4. rst asserted mid-S_HOLD -> state=0 and all counters 0 on the next edge.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and MMCM lock supervisor: waits for a stable lock, then releases mem -> periph -> core.
// Define RST_SEQ_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter on lock_loss_cnt.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 20,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int STEP_CYC        = 16,
    parameter int HOLD_CYC        = 64,
    parameter int DEBOUNCE_CYC    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_rst_req,
    input  logic       btn_rst,
    output logic       rst_mem,
    output logic       rst_periph,
    output logic       rst_core,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] S_SEQ_MEM    = 3'd1;
    localparam logic [2:0] S_SEQ_PERIPH = 3'd2;
    localparam logic [2:0] S_RUN        = 3'd3;
    localparam logic [2:0] S_HOLD       = 3'd4;

    // Terminal values: a wait of N cycles ends on the edge where the counter holds N-1.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Synchronizers for the two asynchronous inputs
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst};
        end
    end

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign btn_s    = btn_sync[SYNC_STAGES-1];

    // Button debounce; the request fires on the same edge the debounced level rises
    logic             btn_level;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_expire;
    logic             btn_req;

    assign deb_expire = (btn_s != btn_level) && (deb_cnt >= DEB_LAST);
    assign btn_req    = deb_expire && btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (btn_s == btn_level) begin
            deb_cnt <= '0;
        end else if (deb_expire) begin
            btn_level <= btn_s;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= sat_inc(deb_cnt);
        end
    end

    // Sequencer FSM; one shared counter serves the stability, step and hold waits
    logic [2:0]       cur;
    logic [CNT_W-1:0] cyc_cnt;
    logic             seq_active;
    logic             lock_lost;
    logic             rst_request;

    assign seq_active  = (cur == S_SEQ_MEM) || (cur == S_SEQ_PERIPH) || (cur == S_RUN);
    assign lock_lost   = seq_active && !locked_s;
    assign rst_request = seq_active && (sw_rst_req || btn_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= S_WAIT_LOCK;
            cyc_cnt    <= '0;
            rst_mem    <= 1'b1;
            rst_periph <= 1'b1;
            rst_core   <= 1'b1;
            ready      <= 1'b0;
        end else if (lock_lost || rst_request) begin
            // Lock loss outranks a simultaneous reset request
            cur        <= lock_lost ? S_WAIT_LOCK : S_HOLD;
            cyc_cnt    <= '0;
            rst_mem    <= 1'b1;
            rst_periph <= 1'b1;
            rst_core   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (cur)
                S_WAIT_LOCK: begin
                    if (!locked_s) begin
                        cyc_cnt <= '0;
                    end else if (cyc_cnt >= LOCK_LAST) begin
                        cur     <= S_SEQ_MEM;
                        cyc_cnt <= '0;
                        rst_mem <= 1'b0;
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                    end
                end
                S_SEQ_MEM: begin
                    if (cyc_cnt >= STEP_LAST) begin
                        cur        <= S_SEQ_PERIPH;
                        cyc_cnt    <= '0;
                        rst_periph <= 1'b0;
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                    end
                end
                S_SEQ_PERIPH: begin
                    if (cyc_cnt >= STEP_LAST) begin
                        cur      <= S_RUN;
                        cyc_cnt  <= '0;
                        rst_core <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                    end
                end
                S_RUN: begin
                    cyc_cnt <= '0;
                end
                S_HOLD: begin
                    if (cyc_cnt >= HOLD_LAST) begin
                        cur     <= S_WAIT_LOCK;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                    end
                end
                default: begin
                    cur        <= S_WAIT_LOCK;
                    cyc_cnt    <= '0;
                    rst_mem    <= 1'b1;
                    rst_periph <= 1'b1;
                    rst_core   <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur;

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if (lock_lost && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector tables feed a scoreboard queue that is checked on the falling clock edge.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       btn_rst = 1'b0;
    logic       rst_mem;
    logic       rst_periph;
    logic       rst_core;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif

    rst_seq_ctrl #(
        .SYNC_STAGES    (2),
        .CNT_W          (20),
        .LOCK_STABLE_CYC(8),
        .STEP_CYC       (4),
        .HOLD_CYC       (6),
        .DEBOUNCE_CYC   (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .sw_rst_req   (sw_rst_req),
        .btn_rst      (btn_rst),
        .rst_mem      (rst_mem),
        .rst_periph   (rst_periph),
        .rst_core     (rst_core),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    rel;
        logic  r;
        logic  lk;
        logic  sw;
        logic  bt;
        int    st;
        int    llc;
        string name;
    } vec_t;

    typedef struct {
        int          at_edge;
        logic [14:0] exp;
        string       name;
    } chk_t;

    vec_t vecs[$];
    chk_t exp_q[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Expected {rst_mem, rst_periph, rst_core, ready, state} for each settled state
    function automatic logic [6:0] outs(input int st);
        case (st)
            0:       return 7'b1110_000;
            1:       return 7'b0110_001;
            2:       return 7'b0010_010;
            3:       return 7'b0001_011;
            4:       return 7'b1110_100;
            default: return 7'b1111_111;
        endcase
    endfunction

    always @(negedge clk) begin : scoreboard
        chk_t        c;
        logic [14:0] got;
        got = {lock_loss_cnt, rst_mem, rst_periph, rst_core, ready, state};
        while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
            c = exp_q.pop_front();
            n_cmp++;
            if (c.at_edge != edge_cnt) begin
                n_bad++;
                $display("FAIL %s: check due at edge %0d reached only at edge %0d", c.name, c.at_edge, edge_cnt);
            end else if (got !== c.exp) begin
                n_bad++;
                $display("FAIL %s @edge %0d: got llc=%0d outs=%b required llc=%0d outs=%b",
                         c.name, edge_cnt, got[14:7], got[6:0], c.exp[14:7], c.exp[6:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chk(input int at, input int st, input int llc, input string name);
        chk_t c;
        c.at_edge = at;
        c.exp     = {(LLC_EN ? 8'(llc) : 8'd0), outs(st)};
        c.name    = name;
        exp_q.push_back(c);
    endtask

    task automatic expect_now(input int st, input int llc, input string name);
        push_chk(edge_cnt, st, llc, name);
    endtask

    task automatic add(input int rel, input logic r, input logic lk, input logic sw, input logic bt,
                       input int st, input int llc, input string name);
        vec_t v;
        v.rel = rel; v.r = r; v.lk = lk; v.sw = sw; v.bt = bt;
        v.st = st; v.llc = llc; v.name = name;
        vecs.push_back(v);
    endtask

    // Each record's inputs are sampled on edge base+rel; its expectation holds after that edge.
    task automatic run_group();
        int base;
        base = edge_cnt;
        foreach (vecs[i]) begin
            while (edge_cnt < base + vecs[i].rel - 1) tick();
            rst        = vecs[i].r;
            locked     = vecs[i].lk;
            sw_rst_req = vecs[i].sw;
            btn_rst    = vecs[i].bt;
            push_chk(base + vecs[i].rel, vecs[i].st, vecs[i].llc, vecs[i].name);
        end
        while (edge_cnt < base + vecs[vecs.size()-1].rel) tick();
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for three edges
        add(1, 1, 0, 0, 0, 0, 0, "rst_e1");
        add(3, 1, 0, 0, 0, 0, 0, "rst_e3");
        run_group();

        // Power-up release: mem at 10, periph at 14, core/ready at 18
        add(1,  0, 1, 0, 0, 0, 0, "pu_e1");
        add(9,  0, 1, 0, 0, 0, 0, "pu_e9_held");
        add(10, 0, 1, 0, 0, 1, 0, "pu_mem");
        add(13, 0, 1, 0, 0, 1, 0, "pu_e13");
        add(14, 0, 1, 0, 0, 2, 0, "pu_periph");
        add(17, 0, 1, 0, 0, 2, 0, "pu_e17");
        add(18, 0, 1, 0, 0, 3, 0, "pu_run");
        add(20, 0, 1, 0, 0, 3, 0, "pu_run_stay");
        run_group();

        // Lock loss in RUN, then relock and full sequence again
        add(1,  0, 0, 0, 0, 3, 0, "ll_e1");
        add(2,  0, 0, 0, 0, 3, 0, "ll_e2");
        add(3,  0, 0, 0, 0, 0, 1, "ll_reset");
        add(4,  0, 1, 0, 0, 0, 1, "ll_relock");
        add(12, 0, 1, 0, 0, 0, 1, "ll_e12");
        add(13, 0, 1, 0, 0, 1, 1, "ll_mem");
        add(17, 0, 1, 0, 0, 2, 1, "ll_periph");
        add(21, 0, 1, 0, 0, 3, 1, "ll_run");
        run_group();

        // Software request in RUN; a second pulse during HOLD is ignored
        add(1,  0, 1, 1, 0, 4, 1, "sw_hold");
        add(2,  0, 1, 0, 0, 4, 1, "sw_e2");
        add(3,  0, 1, 1, 0, 4, 1, "sw_second_ignored");
        add(4,  0, 1, 0, 0, 4, 1, "sw_e4");
        add(6,  0, 1, 0, 0, 4, 1, "sw_hold_last");
        add(7,  0, 1, 0, 0, 0, 1, "sw_wait");
        add(14, 0, 1, 0, 0, 0, 1, "sw_e14");
        add(15, 0, 1, 0, 0, 1, 1, "sw_mem");
        add(19, 0, 1, 0, 0, 2, 1, "sw_periph");
        add(23, 0, 1, 0, 0, 3, 1, "sw_run");
        run_group();

        // Button: short bounce is rejected, a long press gives exactly one request
        add(1,  0, 1, 0, 1, 3, 1, "btn_b1");
        add(2,  0, 1, 0, 0, 3, 1, "btn_b2");
        add(3,  0, 1, 0, 1, 3, 1, "btn_b3");
        add(4,  0, 1, 0, 0, 3, 1, "btn_b4");
        add(7,  0, 1, 0, 0, 3, 1, "btn_bounce_none");
        add(8,  0, 1, 0, 1, 3, 1, "btn_press");
        add(13, 0, 1, 0, 1, 3, 1, "btn_pre_req");
        add(14, 0, 1, 0, 1, 4, 1, "btn_req");
        add(19, 0, 1, 0, 1, 4, 1, "btn_hold_last");
        add(20, 0, 1, 0, 1, 0, 1, "btn_wait");
        add(27, 0, 1, 0, 1, 0, 1, "btn_e27");
        add(28, 0, 1, 0, 0, 1, 1, "btn_mem");
        add(32, 0, 1, 0, 0, 2, 1, "btn_periph");
        add(36, 0, 1, 0, 0, 3, 1, "btn_run");
        add(40, 0, 1, 0, 0, 3, 1, "btn_single_req");
        run_group();

        // Lock loss and sw request on the same edge in SEQ_PERIPH, then into HOLD
        add(1,  0, 1, 1, 0, 4, 1, "co_hold");
        add(2,  0, 1, 0, 0, 4, 1, "co_e2");
        add(7,  0, 1, 0, 0, 0, 1, "co_wait");
        add(15, 0, 1, 0, 0, 1, 1, "co_mem");
        add(19, 0, 1, 0, 0, 2, 1, "co_periph");
        add(20, 0, 0, 0, 0, 2, 1, "co_e20");
        add(21, 0, 0, 0, 0, 2, 1, "co_e21");
        add(22, 0, 0, 1, 0, 0, 2, "coincide_lock_wins");
        add(23, 0, 0, 0, 0, 0, 2, "co_e23");
        add(24, 0, 1, 0, 0, 0, 2, "co_relock");
        add(32, 0, 1, 0, 0, 0, 2, "co_e32");
        add(33, 0, 1, 0, 0, 1, 2, "co_mem2");
        add(35, 0, 1, 1, 0, 4, 2, "co_hold2");
        add(36, 0, 1, 0, 0, 4, 2, "co_e36");
        run_group();

        // rst in the middle of HOLD clears everything including lock_loss_cnt
        rst = 1'b1;
        tick();
        expect_now(0, 0, "rst_mid_hold");
        rst = 1'b0;

        // Unstable lock after reset: 5 samples high, 1 low, then high for good
        repeat (5) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        repeat (7) tick();
        expect_now(0, 0, "unstable_no_early_release");
        repeat (2) tick();
        expect_now(0, 0, "unstable_before_release");
        tick();
        expect_now(1, 0, "unstable_release_mem");
        repeat (4) tick();
        expect_now(2, 0, "unstable_periph");
        repeat (4) tick();
        expect_now(3, 0, "unstable_run");

        repeat (2) tick();
        if (exp_q.size() != 0) begin
            n_bad += exp_q.size();
            $display("FAIL scoreboard_drain: %0d checks pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
